// File: rtl/mul_share_pkg.sv
// Shared types, defaults and the round-robin pick helper for the shared-multiplier arbiter.
package mul_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int MUL_LAT_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int MAX_ID_W    = 3;

  // The ID field is sized for the largest legal requester count; narrower IDs are zero-extended.
  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // One-hot pick of the first set mask bit at or after ptr, wrapping at n-1.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (k < n && !found && mask[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester, response and multiplier-side signals of the shared-multiplier arbiter.
interface mul_share_arbiter_if import mul_share_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_data;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_en_in;
  logic                     mul_en_out;
  logic [2*WIDTH-1:0]       mul_out;

  modport slave (
    input  req_valid, req_a, req_b, mul_en_out, mul_out,
    output req_ready, rsp_valid, rsp_id, rsp_data, mul_a, mul_b, mul_en_in
  );

  modport master (
    output req_valid, req_a, req_b, mul_en_out, mul_out,
    input  req_ready, rsp_valid, rsp_id, rsp_data, mul_a, mul_b, mul_en_in
  );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin grant: one-hot grant plus its encoded requester ID.
module mul_rr_arbiter import mul_share_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [MAX_REQ-1:0] mask;

  always_comb begin
    mask               = '0;
    mask[NUM_REQ-1:0]  = req_valid;
    grant              = arb_en ? NUM_REQ'(rr_pick(mask, 32'(ptr), NUM_REQ)) : '0;
    grant_id           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters, returning
// each product to its originator and flagging multiplier valid misalignment.
module mul_share_arbiter import mul_share_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic err_clr,
  output logic busy,
  output logic err_sync,
  mul_share_arbiter_if.slave bus
);
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    issue_id_p0;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  tag_t               tag_p [MUL_LAT];
  tag_t               head;

  mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .arb_en    (arb_en),
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign bus.req_ready = grant;
  assign xfer          = |(grant & bus.req_valid);
  assign head          = tag_p[MUL_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (xfer) ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  end

  // Issue stage: granted operands onto the multiplier inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_en_in <= 1'b0;
      issue_id_p0   <= '0;
    end else if (xfer) begin
      bus.mul_a     <= bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
      bus.mul_b     <= bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
      bus.mul_en_in <= 1'b1;
      issue_id_p0   <= grant_id;
    end else begin
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.mul_en_in <= 1'b0;
      issue_id_p0   <= '0;
    end
  end

  // Tag stages: mirror the multiplier so the head lines up with mul_en_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= '{vld: bus.mul_en_in, id: MAX_ID_W'(issue_id_p0)};
      for (int k = 1; k < MUL_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  // Result stage: a product is delivered only when tag and multiplier agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else if (head.vld && bus.mul_en_out) begin
      bus.rsp_valid <= NUM_REQ'(1) << head.id;
      bus.rsp_id    <= ID_W'(head.id);
      bus.rsp_data  <= bus.mul_out;
    end else begin
      bus.rsp_valid <= '0;
    end
  end

  // A fresh mismatch outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_sync <= 1'b0;
    else if (head.vld != bus.mul_en_out)    err_sync <= 1'b1;
    else if (err_clr)                       err_sync <= 1'b0;
  end

  always_comb begin
    busy = bus.mul_en_in;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | tag_p[k].vld;
  end
endmodule
